// File: rtl/ring_counter.sv
// ring_counter
//   One-hot ring counter. A single hot bit circulates through a WIDTH-bit
//   register, advancing one position per clock. It free-runs whenever reset
//   is low. A non-one-hot state (zero or multiple bits set) is replaced by the
//   reset pattern on the next edge, and that edge is flagged.
//
// Parameters
//   WIDTH       number of stages in the ring (>= 2)
//   ROTATE_LEFT 1: hot bit moves toward the MSB, 0: toward the LSB
//   RESET_POS   bit index that is hot after reset (0 <= RESET_POS < WIDTH)
//
// Ports
//   clk     in   clock, rising-edge active
//   reset   in   synchronous, active-high reset
//   count   out  registered one-hot ring state
//   index   out  registered binary position of the hot bit in count
//   wrap    out  registered pulse, high when count has just returned to the
//                reset pattern by rotation
//   illegal out  registered pulse, high for the cycle after a non-one-hot
//                count was replaced by the reset pattern
module ring_counter #(
    parameter int WIDTH       = 4,
    parameter bit ROTATE_LEFT = 1'b1,
    parameter int RESET_POS   = 0,
    localparam int IW         = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic [IW-1:0]    index,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_PAT = ONE << RESET_POS;
    localparam logic [IW-1:0]    RST_IDX = IW'(RESET_POS);
    localparam logic [IW-1:0]    LAST    = IW'(WIDTH - 1);

    logic [WIDTH-1:0] count_nxt;
    logic [IW-1:0]    index_nxt;
    logic             onehot;

    // x & (x-1) clears the lowest set bit; zero result on a non-zero x
    // means exactly one bit was set.
    assign onehot = (count != '0) && ((count & (count - ONE)) == '0);

    // Index is tracked alongside the ring rather than encoded from it, so it
    // stays a plain register. It wraps explicitly at WIDTH-1 so non-power-of-2
    // widths stay in range.
    always_comb begin
        count_nxt = count;
        index_nxt = index;
        if (ROTATE_LEFT) begin
            count_nxt = {count[WIDTH-2:0], count[WIDTH-1]};
            index_nxt = (index == LAST) ? '0 : index + IW'(1);
        end else begin
            count_nxt = {count[0], count[WIDTH-1:1]};
            index_nxt = (index == '0) ? LAST : index - IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= RST_PAT;
            index   <= RST_IDX;
            wrap    <= 1'b0;
            illegal <= 1'b0;
        end else if (!onehot) begin
            // Recovery reloads the reset pattern; rotation resumes next edge.
            count   <= RST_PAT;
            index   <= RST_IDX;
            wrap    <= 1'b0;
            illegal <= 1'b1;
        end else begin
            count   <= count_nxt;
            index   <= index_nxt;
            wrap    <= (count_nxt == RST_PAT);
            illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter
//   Directed bench for ring_counter. Four instances share clock and reset:
//   defaults (4-bit, left, pos 0), right-rotating 4-bit from pos 3, and
//   2-bit / 8-bit left rotators. Expected values are hand-derived from the
//   step number after reset release.
module tb_ring_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic [3:0] d_cnt;  logic [1:0] d_idx;  logic d_wrap, d_ill;
    logic [3:0] r_cnt;  logic [1:0] r_idx;  logic r_wrap, r_ill;
    logic [1:0] w2_cnt; logic       w2_idx; logic w2_wrap, w2_ill;
    logic [7:0] w8_cnt; logic [2:0] w8_idx; logic w8_wrap, w8_ill;

    int n_chk = 0;
    int n_err = 0;

    ring_counter #(.WIDTH(4), .ROTATE_LEFT(1'b1), .RESET_POS(0)) u_def (
        .clk(clk), .reset(reset), .count(d_cnt), .index(d_idx),
        .wrap(d_wrap), .illegal(d_ill));

    ring_counter #(.WIDTH(4), .ROTATE_LEFT(1'b0), .RESET_POS(3)) u_rgt (
        .clk(clk), .reset(reset), .count(r_cnt), .index(r_idx),
        .wrap(r_wrap), .illegal(r_ill));

    ring_counter #(.WIDTH(2), .ROTATE_LEFT(1'b1), .RESET_POS(0)) u_w2 (
        .clk(clk), .reset(reset), .count(w2_cnt), .index(w2_idx),
        .wrap(w2_wrap), .illegal(w2_ill));

    ring_counter #(.WIDTH(8), .ROTATE_LEFT(1'b1), .RESET_POS(0)) u_w8 (
        .clk(clk), .reset(reset), .count(w8_cnt), .index(w8_idx),
        .wrap(w8_wrap), .illegal(w8_ill));

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_def(input string tag, input logic [3:0] c, input logic [1:0] i,
                           input logic w, input logic il);
        chk({tag, ".count"},   32'(d_cnt),  32'(c));
        chk({tag, ".index"},   32'(d_idx),  32'(i));
        chk({tag, ".wrap"},    32'(d_wrap), 32'(w));
        chk({tag, ".illegal"}, 32'(d_ill),  32'(il));
    endtask

    initial begin
        logic [3:0] ed, er;
        logic [1:0] e2;
        logic [7:0] e8;
        int         wraps8;

        // Two reset edges: all instances sit at their reset pattern.
        reset = 1'b1;
        step();
        step();
        chk_def("rst", 4'b0001, 2'd0, 1'b0, 1'b0);
        chk("rst.rgt.count", 32'(r_cnt), 32'h8);
        chk("rst.rgt.index", 32'(r_idx), 32'd3);
        chk("rst.w2.count",  32'(w2_cnt), 32'h1);
        chk("rst.w8.count",  32'(w8_cnt), 32'h01);
        chk("rst.w8.wrap",   32'(w8_wrap), 32'd0);

        // Free run for two full 8-bit periods.
        reset = 1'b0;
        wraps8 = 0;
        for (int k = 1; k <= 16; k++) begin
            ed = 4'b0001 << (k % 4);
            er = 4'b1000 >> (k % 4);
            e2 = 2'b01 << (k % 2);
            e8 = 8'h01 << (k % 8);
            step();
            chk_def($sformatf("run%0d", k), ed, 2'(k % 4), (k % 4) == 0, 1'b0);
            chk($sformatf("run%0d.rgt.count", k), 32'(r_cnt),  32'(er));
            chk($sformatf("run%0d.rgt.index", k), 32'(r_idx),  32'(3 - (k % 4)));
            chk($sformatf("run%0d.rgt.wrap", k),  32'(r_wrap), 32'((k % 4) == 0));
            chk($sformatf("run%0d.w2.count", k),  32'(w2_cnt), 32'(e2));
            chk($sformatf("run%0d.w2.index", k),  32'(w2_idx), 32'(k % 2));
            chk($sformatf("run%0d.w2.wrap", k),   32'(w2_wrap), 32'((k % 2) == 0));
            chk($sformatf("run%0d.w8.count", k),  32'(w8_cnt), 32'(e8));
            chk($sformatf("run%0d.w8.index", k),  32'(w8_idx), 32'(k % 8));
            if (w8_wrap) wraps8++;
        end
        chk("w8.wraps_per_16", 32'(wraps8), 32'd2);

        // Long reset hold: pattern and flags stay parked.
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk_def($sformatf("hold%0d", k), 4'b0001, 2'd0, 1'b0, 1'b0);
        end

        // Mid-sequence reset from 0100.
        reset = 1'b0;
        step();
        step();
        chk_def("mid.pre", 4'b0100, 2'd2, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_def("mid.rst", 4'b0001, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_def("mid.resume", 4'b0010, 2'd1, 1'b0, 1'b0);

        // Two hot bits: recovered to the reset pattern in one edge.
        force u_def.count = 4'b0110;
        #1;
        release u_def.count;
        step();
        chk_def("ill2.rec", 4'b0001, 2'd0, 1'b0, 1'b1);
        step();
        chk_def("ill2.run", 4'b0010, 2'd1, 1'b0, 1'b0);

        // No hot bit: same response.
        force u_def.count = 4'b0000;
        #1;
        release u_def.count;
        step();
        chk_def("ill0.rec", 4'b0001, 2'd0, 1'b0, 1'b1);
        step();
        chk_def("ill0.run", 4'b0010, 2'd1, 1'b0, 1'b0);
        step();
        chk_def("ill0.run2", 4'b0100, 2'd2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
